// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between ICache refills
// and DCache refills/write-backs. Reads go DCache-first, with a streak limit
// so a waiting ICache is not starved. Write-backs run on their own FSM, and a
// DCache read aimed at the line being written back waits for that write.
module cache_mem_arbiter #(
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_req,
  input  logic [31:0]       i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic [LINE_W-1:0] i_ret_data,
  input  logic              d_rd_req,
  input  logic [31:0]       d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic [LINE_W-1:0] d_ret_data,
  input  logic              d_wr_req,
  input  logic [31:0]       d_wr_addr,
  input  logic [LINE_W-1:0] d_wr_data,
  output logic              d_wr_rdy,
  output logic              d_wr_valid,
  output logic              m_rd_req,
  output logic [31:0]       m_rd_addr,
  input  logic              m_rd_rdy,
  input  logic              m_ret_valid,
  input  logic [LINE_W-1:0] m_ret_data,
  output logic              m_wr_req,
  output logic [31:0]       m_wr_addr,
  output logic [LINE_W-1:0] m_wr_data,
  input  logic              m_wr_rdy,
  input  logic              m_wr_valid
);
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} w_state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  r_state_e          r_state_q, r_state_d;
  logic              owner_q, owner_d;        // 1 = DCache owns the read
  logic [3:0]        streak_q, streak_d;
  logic [31:0]       rd_addr_q, rd_addr_d;
  w_state_e          w_state_q, w_state_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0] wr_data_q, wr_data_d;

  logic wr_busy, d_elig, i_win;

  // A DCache read of the line currently being written back must not overtake it
  assign wr_busy = (w_state_q != W_IDLE);
  assign d_elig  = d_rd_req && !(wr_busy && (d_rd_addr[31:4] == wr_addr_q[31:4]));
  assign i_win   = i_rd_req && (!d_elig || (streak_q == LIMIT));

  // Read FSM next state: grant, address latch and starvation streak
  always_comb begin
    r_state_d = r_state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    rd_addr_d = rd_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (i_win) begin
          owner_d   = 1'b0;
          rd_addr_d = i_rd_addr;
          streak_d  = 4'd0;
          r_state_d = R_REQ;
        end else if (d_elig) begin
          owner_d   = 1'b1;
          rd_addr_d = d_rd_addr;
          if (!i_rd_req)              streak_d = 4'd0;
          else if (streak_q != LIMIT) streak_d = streak_q + 4'd1;
          r_state_d = R_REQ;
        end
      end
      R_REQ:   if (m_rd_rdy)    r_state_d = R_WAIT;
      R_WAIT:  if (m_ret_valid) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write-back FSM next state: latch line on request, then request/complete
  always_comb begin
    w_state_d = w_state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (w_state_q)
      W_IDLE: if (d_wr_req) begin
        wr_addr_d = d_wr_addr;
        wr_data_d = d_wr_data;
        w_state_d = W_REQ;
      end
      W_REQ:   if (m_wr_rdy)   w_state_d = W_WAIT;
      W_WAIT:  if (m_wr_valid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // State registers for both FSMs; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      owner_q   <= 1'b0;
      streak_q  <= 4'd0;
      rd_addr_q <= '0;
      w_state_q <= W_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      rd_addr_q <= rd_addr_d;
      w_state_q <= w_state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Handshake pulses are decoded from registered state plus the bridge inputs
  always_comb begin
    m_rd_req    = (r_state_q == R_REQ);
    m_rd_addr   = rd_addr_q;
    i_rd_rdy    = m_rd_req && m_rd_rdy && !owner_q;
    d_rd_rdy    = m_rd_req && m_rd_rdy &&  owner_q;
    i_ret_valid = (r_state_q == R_WAIT) && m_ret_valid && !owner_q;
    d_ret_valid = (r_state_q == R_WAIT) && m_ret_valid &&  owner_q;
    // Data is a passthrough, forced to zero while reset is held
    i_ret_data  = rst ? '0 : m_ret_data;
    d_ret_data  = rst ? '0 : m_ret_data;
    m_wr_req    = (w_state_q == W_REQ);
    m_wr_addr   = wr_addr_q;
    m_wr_data   = wr_data_q;
    d_wr_rdy    = m_wr_req && m_wr_rdy;
    d_wr_valid  = (w_state_q == W_WAIT) && m_wr_valid;
  end
endmodule
